// File: rtl/uart_baud_rx.sv
// uart_baud_rx: programmable 16x baud divider, bit-rate clock stage and
// oversampling 8-bit frame receiver, all on one system clock with tick enables.
module uart_baud_rx #(
  parameter int unsigned DIV_W  = 16,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DIV_W-1:0]  div,
  input  logic              ideal_rx,
  input  logic              parity_en,
  input  logic              parity_even,
  input  logic              rx,
  output logic              br,
  output logic              baud_clk,
  output logic              baud_tick,
  output logic [DATA_W-1:0] rv_data,
  output logic              rx_valid,
  output logic              parity_err,
  output logic              frame_err
);

  localparam int unsigned OS_W = 4;
  localparam int unsigned BC_W = 4;
  localparam int unsigned BI_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  logic [DIV_W-1:0]  cnt16_q, cnt16_d;
  logic [DIV_W-1:0]  div_m1;
  logic              br_q, br_d;
  logic [BC_W-1:0]   bcnt_q, bcnt_d;
  logic              baud_clk_q, baud_clk_d;
  logic              baud_tick_q, baud_tick_d;
  logic              rx_s1_q, rx_s1_d;
  logic              rx_s2_q, rx_s2_d;
  state_t            state_q, state_d;
  logic [OS_W-1:0]   os_q, os_d;
  logic [BI_W-1:0]   bit_idx_q, bit_idx_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              par_pend_q, par_pend_d;
  logic [DATA_W-1:0] rv_data_q, rv_data_d;
  logic              rx_valid_q, rx_valid_d;
  logic              parity_err_q, parity_err_d;
  logic              frame_err_q, frame_err_d;

  // Divider and baud stage next-state: br tick generation and bit-rate clock.
  always_comb begin
    div_m1      = (div == '0) ? '0 : div - DIV_W'(1);
    cnt16_d     = cnt16_q + DIV_W'(1);
    br_d        = 1'b0;
    bcnt_d      = bcnt_q;
    baud_clk_d  = baud_clk_q;
    baud_tick_d = 1'b0;
    // >= lets a shrinking divisor wrap on the next increment
    if (cnt16_q >= div_m1) begin
      cnt16_d = '0;
      br_d    = 1'b1;
    end
    if (br_q) begin
      bcnt_d      = bcnt_q + BC_W'(1);
      baud_clk_d  = ~bcnt_d[BC_W-1];
      baud_tick_d = (bcnt_q == BC_W'(15));
    end
  end

  // Receiver next-state: synchroniser, oversampling FSM and result capture.
  always_comb begin
    rx_s1_d      = rx;
    rx_s2_d      = rx_s1_q;
    state_d      = state_q;
    os_d         = os_q;
    bit_idx_d    = bit_idx_q;
    shift_d      = shift_q;
    par_pend_d   = par_pend_q;
    rv_data_d    = rv_data_q;
    rx_valid_d   = 1'b0;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;
    if (ideal_rx) begin
      state_d   = S_IDLE;
      os_d      = '0;
      bit_idx_d = '0;
      rv_data_d = '0;
    end else if (br_q) begin
      case (state_q)
        S_IDLE: begin
          os_d = '0;
          if (!rx_s2_q) begin
            state_d   = S_START;
            bit_idx_d = '0;
          end
        end
        S_START: begin
          if (os_q == OS_W'(7)) begin
            os_d    = '0;
            state_d = rx_s2_q ? S_IDLE : S_DATA;
          end else begin
            os_d = os_q + OS_W'(1);
          end
        end
        S_DATA: begin
          os_d = os_q + OS_W'(1);
          if (os_q == OS_W'(15)) begin
            shift_d   = {rx_s2_q, shift_q[DATA_W-1:1]};
            bit_idx_d = bit_idx_q + BI_W'(1);
            if (bit_idx_q == BI_W'(DATA_W - 1)) begin
              bit_idx_d  = '0;
              par_pend_d = 1'b0;
              state_d    = parity_en ? S_PARITY : S_STOP;
            end
          end
        end
        S_PARITY: begin
          os_d = os_q + OS_W'(1);
          if (os_q == OS_W'(15)) begin
            par_pend_d = (^shift_q) ^ rx_s2_q ^ ~parity_even;
            state_d    = S_STOP;
          end
        end
        S_STOP: begin
          os_d = os_q + OS_W'(1);
          if (os_q == OS_W'(15)) begin
            rv_data_d    = shift_q;
            frame_err_d  = ~rx_s2_q;
            parity_err_d = par_pend_q;
            rx_valid_d   = 1'b1;
            os_d         = '0;
            state_d      = S_IDLE;
          end
        end
        default: begin
          state_d = S_IDLE;
          os_d    = '0;
        end
      endcase
    end
  end

  // All state registers; asynchronous active-high reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt16_q      <= '0;
      br_q         <= 1'b0;
      bcnt_q       <= '0;
      baud_clk_q   <= 1'b0;
      baud_tick_q  <= 1'b0;
      rx_s1_q      <= 1'b1;
      rx_s2_q      <= 1'b1;
      state_q      <= S_IDLE;
      os_q         <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      par_pend_q   <= 1'b0;
      rv_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      cnt16_q      <= cnt16_d;
      br_q         <= br_d;
      bcnt_q       <= bcnt_d;
      baud_clk_q   <= baud_clk_d;
      baud_tick_q  <= baud_tick_d;
      rx_s1_q      <= rx_s1_d;
      rx_s2_q      <= rx_s2_d;
      state_q      <= state_d;
      os_q         <= os_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      par_pend_q   <= par_pend_d;
      rv_data_q    <= rv_data_d;
      rx_valid_q   <= rx_valid_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign br         = br_q;
  assign baud_clk   = baud_clk_q;
  assign baud_tick  = baud_tick_q;
  assign rv_data    = rv_data_q;
  assign rx_valid   = rx_valid_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_uart_baud_rx.sv
// Bench for uart_baud_rx: directed corner cases plus randomized frames,
// checked against a frame-level reference model.
module tb_uart_baud_rx;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] div;
  logic        ideal_rx, parity_en, parity_even, rx;
  logic        br, baud_clk, baud_tick, rx_valid, parity_err, frame_err;
  logic [7:0]  rv_data;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int          cyc = 0;

  typedef struct packed {
    logic [7:0] d;
    logic       pe;
    logic       fe;
    int         c;
  } rec_t;

  rec_t rxq[$];

  uart_baud_rx dut (
    .clk        (clk),
    .rst        (rst),
    .div        (div),
    .ideal_rx   (ideal_rx),
    .parity_en  (parity_en),
    .parity_even(parity_even),
    .rx         (rx),
    .br         (br),
    .baud_clk   (baud_clk),
    .baud_tick  (baud_tick),
    .rv_data    (rv_data),
    .rx_valid   (rx_valid),
    .parity_err (parity_err),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every delivered frame with its arrival cycle.
  always @(negedge clk) begin
    if (rx_valid) rxq.push_back(rec_t'{d: rv_data, pe: parity_err, fe: frame_err, c: cyc});
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Parity bit a correct transmitter would send.
  function automatic logic tx_parity(input logic [7:0] b, input logic even);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(b[i]);
    return even ? logic'(ones % 2) : logic'((ones + 1) % 2);
  endfunction

  // Expected parity flag from the bit that was actually sent.
  function automatic logic exp_perr(input logic [7:0] b, input logic pen, input logic even,
                                    input logic pbit);
    int ones = int'(pbit);
    for (int i = 0; i < 8; i++) ones += int'(b[i]);
    if (!pen) return 1'b0;
    return even ? (ones % 2 != 0) : (ones % 2 == 0);
  endfunction

  task automatic send_frame(input logic [7:0] b, input logic flip, input logic stop_v,
                            output int start_cyc);
    int bc;
    bc = 16 * int'(div);
    @(negedge clk);
    rx = 1'b0;
    start_cyc = cyc;
    repeat (bc) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (bc) @(negedge clk);
    end
    if (parity_en) begin
      rx = tx_parity(b, parity_even) ^ flip;
      repeat (bc) @(negedge clk);
    end
    rx = stop_v;
    repeat (bc) @(negedge clk);
    rx = 1'b1;
    repeat (2 * bc) @(negedge clk);
  endtask

  task automatic expect_frame(input string tag, input logic [7:0] d, input logic pe,
                              input logic fe);
    rec_t r;
    check({tag, ".cnt"}, rxq.size(), 1);
    if (rxq.size() > 0) begin
      r = rxq.pop_front();
      check({tag, ".data"}, r.d, d);
      check({tag, ".perr"}, r.pe, pe);
      check({tag, ".ferr"}, r.fe, fe);
    end
    rxq.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int sc, lat, n, hi, per, found;
    logic [7:0] b;
    logic flip, stop_v, pbit;

    rst = 1'b1; div = 16'd2; ideal_rx = 1'b0; parity_en = 1'b0; parity_even = 1'b0; rx = 1'b1;
    repeat (5) @(negedge clk);
    check("rst.br", br, 0);
    check("rst.baud_clk", baud_clk, 0);
    check("rst.baud_tick", baud_tick, 0);
    check("rst.rx_valid", rx_valid, 0);
    check("rst.parity_err", parity_err, 0);
    check("rst.frame_err", frame_err, 0);
    check("rst.rv_data", rv_data, 0);
    rst = 1'b0;
    repeat (10) @(negedge clk);

    // Plain 8N1 frame with latency window.
    send_frame(8'hB8, 1'b0, 1'b1, sc);
    if (rxq.size() > 0) begin
      lat = rxq[0].c - sc;
      check("b8.latency_300_308", (lat >= 300 && lat <= 308), 1);
    end
    expect_frame("b8", 8'hB8, 1'b0, 1'b0);

    // Asynchronous reset while br and baud_clk are high.
    found = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (br && baud_clk) begin found = 1; break; end
    end
    check("mid_rst.found_br_hi", found, 1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst.br", br, 0);
    check("mid_rst.baud_clk", baud_clk, 0);
    check("mid_rst.rv_data", rv_data, 0);
    @(negedge clk); rst = 1'b0;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1; n++;
      if (br) break;
    end
    check("br.first_clk", n, 2);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1; n++;
      if (br) break;
    end
    check("br.period", n, 2);

    // Baud clock period and duty, tick aligned with rising edge.
    found = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (baud_tick) begin found = 1; break; end
    end
    check("baud.tick_seen", found, 1);
    check("baud.tick_on_rise", baud_clk, 1);
    hi = 0; per = 0;
    for (int i = 0; i < 64; i++) begin
      if (baud_clk) hi++;
      @(posedge clk); #1; per++;
      if (baud_tick) break;
    end
    check("baud.period", per, 32);
    check("baud.high", hi, 16);

    // Odd parity, correct and corrupted parity bit.
    parity_en = 1'b1; parity_even = 1'b0;
    send_frame(8'h2F, 1'b0, 1'b1, sc);
    expect_frame("par_ok", 8'h2F, 1'b0, 1'b0);
    send_frame(8'h2F, 1'b1, 1'b1, sc);
    expect_frame("par_bad", 8'h2F, 1'b1, 1'b0);
    parity_en = 1'b0;

    // Stop bit low.
    send_frame(8'h55, 1'b0, 1'b0, sc);
    expect_frame("stop_low", 8'h55, 1'b0, 1'b1);

    // Short low glitch is rejected as a false start.
    @(negedge clk); rx = 1'b0;
    repeat (8) @(negedge clk);
    rx = 1'b1;
    repeat (96) @(negedge clk);
    check("glitch.cnt", rxq.size(), 0);
    rxq.delete();
    send_frame(8'hAA, 1'b0, 1'b1, sc);
    expect_frame("after_glitch", 8'hAA, 1'b0, 1'b0);

    // ideal_rx mid-frame aborts and clears.
    fork
      send_frame(8'h99, 1'b0, 1'b1, sc);
      begin
        repeat (5 * 32) @(negedge clk);
        ideal_rx = 1'b1;
        repeat (3) @(negedge clk);
        check("ideal.rv_data", rv_data, 0);
      end
    join
    ideal_rx = 1'b0;
    check("ideal.cnt", rxq.size(), 0);
    rxq.delete();
    send_frame(8'h42, 1'b0, 1'b1, sc);
    expect_frame("after_ideal", 8'h42, 1'b0, 1'b0);

    // Break: back-to-back frames of zeros with framing error.
    @(negedge clk); rx = 1'b0;
    repeat (22 * 32) @(negedge clk);
    rx = 1'b1;
    repeat (14 * 32) @(negedge clk);
    check("break.cnt_ge2", rxq.size() >= 2, 1);
    if (rxq.size() >= 2) begin
      check("break.f0.data", rxq[0].d, 0);
      check("break.f0.ferr", rxq[0].fe, 1);
      check("break.f1.data", rxq[1].d, 0);
      check("break.f1.ferr", rxq[1].fe, 1);
    end
    ideal_rx = 1'b1;
    repeat (2) @(negedge clk);
    ideal_rx = 1'b0;
    rxq.delete();

    // Randomized frames against the frame model.
    for (int k = 0; k < 6; k++) begin
      div = 16'($urandom_range(4, 2));
      repeat (256) @(negedge clk);
      rxq.delete();
      b           = 8'($urandom);
      parity_en   = 1'($urandom);
      parity_even = 1'($urandom);
      flip        = 1'($urandom);
      stop_v      = ($urandom % 4) != 0;
      pbit        = tx_parity(b, parity_even) ^ flip;
      send_frame(b, flip, stop_v, sc);
      expect_frame($sformatf("rnd%0d", k), b, exp_perr(b, parity_en, parity_even, pbit), ~stop_v);
    end

    // div=0 behaves as div=1: br every cycle.
    div = 16'd0;
    repeat (4) @(negedge clk);
    hi = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (br) hi++;
    end
    check("div0.br_every_clk", hi, 8);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
